// File: rtl/interrupciones_pkg.sv
// Shared definitions for the interrupt controller: FSM states, the field
// layout of the interrupt word and the number of request sources.
package interrupciones_pkg;

  localparam int NSRC      = 7;
  localparam int VALID_BIT = 7;
  localparam int ID_MSB    = 6;
  localparam int ID_LSB    = 4;
  localparam int SEQ_MSB   = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } estado_t;

  // Largest of three cycle counts, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prioridad_int.sv
// Combinational 7-to-3 priority encoder: the highest set index wins and is
// reported as id = index + 1; any_o flags that at least one request is set.
module prioridad_int
  import interrupciones_pkg::*;
(
  input  logic [NSRC-1:0] req_i,
  output logic [2:0]      id_o,
  output logic            any_o
);

  // Scan upward so the last (highest) set bit overrides lower ones.
  always_comb begin
    id_o  = '0;
    any_o = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (req_i[i]) begin
        id_o  = 3'(i + 1);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_interrupciones.sv
// Interrupt source for the monocycle CPU: latches request edges, picks the
// highest-priority eligible source, frames it as {valid, id, seq}, waits for
// the acknowledge with bounded retries and enforces an idle gap afterwards.
module controlador_interrupciones
  import interrupciones_pkg::*;
#(
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic [NSRC-1:0] mascara,
  input  logic            ack,
  output logic [7:0]      interrupcion,
  output logic            ocupado,
  output logic            perdida
);

  localparam int CNT_MAX  = max3(PULSE_CYCLES, TIMEOUT, GAP_CYCLES);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int SEQ_W    = SEQ_MSB + 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_END  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_LAST);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  // Where a finished service (ack or drop) lands.
  localparam estado_t DONE_ST = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  estado_t          state_q, state_d;
  logic [NSRC-1:0]  irq_prev_q;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [2:0]       id_srv_q, id_srv_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       word_q, word_d;
  logic             perdida_q;
  logic             clr_srv, drop;
  logic [NSRC-1:0]  clr_mask;
  logic [2:0]       id_sel;
  logic             any_sel;

  prioridad_int u_prioridad (
    .req_i (pend_q & mascara),
    .id_o  (id_sel),
    .any_o (any_sel)
  );

  // Service FSM: next state, served id, retry/sequence and phase counter.
  always_comb begin
    state_d  = state_q;
    id_srv_d = id_srv_q;
    retry_d  = retry_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    clr_srv  = 1'b0;
    drop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_sel) begin
          id_srv_d = id_sel;
          retry_d  = '0;
          cnt_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack) begin
          clr_srv = 1'b1;
          seq_d   = seq_q + 1'b1;
          cnt_d   = '0;
          state_d = DONE_ST;
        end else if (cnt_q == PULSE_END) begin
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          clr_srv = 1'b1;
          seq_d   = seq_q + 1'b1;
          cnt_d   = '0;
          state_d = DONE_ST;
        end else if (cnt_q == TOUT_END) begin
          cnt_d = '0;
          if (retry_q == RTY_MAX) begin
            clr_srv = 1'b1;
            drop    = 1'b1;
            seq_d   = seq_q + 1'b1;
            state_d = DONE_ST;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending bits: clearing the served source loses to a fresh edge on it.
  always_comb begin
    clr_mask = clr_srv ? (NSRC'(1) << (id_srv_q - 3'd1)) : '0;
    pend_d   = (pend_q & ~clr_mask) | (irq & ~irq_prev_q);
  end

  // Registered interrupt word, built from the state being entered.
  always_comb begin
    word_d = '0;
    if (state_d == ST_ISSUE) begin
      word_d[VALID_BIT]      = 1'b1;
      word_d[ID_MSB:ID_LSB]  = id_srv_d;
      word_d[SEQ_MSB:0]      = seq_d;
    end
  end

  // All state, including the output word, clears immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      irq_prev_q <= '0;
      pend_q     <= '0;
      id_srv_q   <= '0;
      retry_q    <= '0;
      seq_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      perdida_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq;
      pend_q     <= pend_d;
      id_srv_q   <= id_srv_d;
      retry_q    <= retry_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      perdida_q  <= drop;
    end
  end

  assign interrupcion = word_q;
  assign ocupado      = (state_q != ST_IDLE);
  assign perdida      = perdida_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Bench for controlador_interrupciones: directed retry/mask/reset scenarios
// followed by randomized request/mask/ack traffic scored against a
// transaction-level model (pending set, priority pick, sequence count).
module tb_controlador_interrupciones;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] irq;
  logic [6:0] mascara;
  logic       ack;
  logic [7:0] interrupcion;
  logic       ocupado;
  logic       perdida;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [6:0] ref_pend;
  int         ref_seq;
  int         ref_win;

  controlador_interrupciones dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .mascara      (mascara),
    .ack          (ack),
    .interrupcion (interrupcion),
    .ocupado      (ocupado),
    .perdida      (perdida)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int best(input logic [6:0] v);
    int w;
    w = 0;
    for (int i = 0; i < 7; i++) if (v[i]) w = i + 1;
    return w;
  endfunction

  function automatic logic [7:0] exp_word();
    return {1'b1, 3'(ref_win), 4'(ref_seq)};
  endfunction

  // Called in the first ISSUE cycle: ack after d cycles, then walk the gap.
  task automatic serve(input int d, input logic [6:0] mid_mask);
    irq     = '0;
    mascara = mid_mask;
    if (d == 0) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end else begin
      for (int j = 0; j < d; j++) begin
        tick();
        chk("wait_word", interrupcion, 8'h00);
        chk("wait_busy", 8'(ocupado), 8'd1);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    ref_pend[ref_win-1] = 1'b0;
    ref_seq = (ref_seq + 1) % 16;
    chk("gap1_word", interrupcion, 8'h00);
    chk("gap1_busy", 8'(ocupado), 8'd1);
    chk("gap1_lost", 8'(perdida), 8'd0);
    ack = 1'($urandom_range(0, 1));
    tick();
    chk("gap2_word", interrupcion, 8'h00);
    chk("gap2_busy", 8'(ocupado), 8'd1);
    ack = 1'($urandom_range(0, 1));
    tick();
    ack = 1'b0;
    chk("idle_word", interrupcion, 8'h00);
    chk("idle_busy", 8'(ocupado), 8'd0);
  endtask

  initial begin
    logic [6:0] r, m, elig;
    reset    = 1'b1;
    irq      = '0;
    mascara  = '0;
    ack      = 1'b0;
    ref_pend = '0;
    ref_seq  = 0;
    ref_win  = 0;
    tick();
    tick();
    chk("rst_word", interrupcion, 8'h00);
    chk("rst_busy", 8'(ocupado), 8'd0);
    chk("rst_lost", 8'(perdida), 8'd0);
    reset = 1'b0;
    tick();

    // Source 2 never acknowledged: four issues 17 cycles apart, then a drop.
    mascara = 7'h7F;
    irq     = 7'b0000010;
    tick();
    chk("nack_pre", interrupcion, 8'h00);
    tick();
    irq = '0;
    chk("nack_c0", interrupcion, 8'b1010_0000);
    for (int c = 1; c < 68; c++) begin
      tick();
      chk("nack_word", interrupcion, (c % 17 == 0) ? 8'b1010_0000 : 8'h00);
      chk("nack_lost", 8'(perdida), 8'd0);
    end
    tick();
    chk("drop_lost", 8'(perdida), 8'd1);
    chk("drop_word", interrupcion, 8'h00);
    tick();
    chk("drop_pulse", 8'(perdida), 8'd0);
    ref_seq = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("drop_idle", 8'(ocupado), 8'd0);
    end

    // Masked source 3 waits until unmasked, then issues the next cycle.
    mascara = 7'h7B;
    irq     = 7'b0000100;
    ref_pend[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mask_word", interrupcion, 8'h00);
      chk("mask_busy", 8'(ocupado), 8'd0);
    end
    mascara = 7'h7F;
    tick();
    ref_win = 3;
    chk("unmask_word", interrupcion, exp_word());
    serve(2, 7'h7F);

    // Asynchronous reset in the middle of an ISSUE cycle.
    irq = 7'b1000000;
    tick();
    tick();
    ref_win = 7;
    chk("pre_rst_word", interrupcion, exp_word());
    #3;
    reset = 1'b1;
    irq   = '0;
    #1;
    chk("async_word", interrupcion, 8'h00);
    chk("async_busy", 8'(ocupado), 8'd0);
    tick();
    tick();
    reset    = 1'b0;
    ref_pend = '0;
    ref_seq  = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_word", interrupcion, 8'h00);
      chk("post_rst_busy", 8'(ocupado), 8'd0);
    end

    // Randomized traffic; each pass starts in an IDLE cycle with irq low.
    for (int it = 0; it < 60; it++) begin
      r = 7'($urandom_range(1, 127));
      m = 7'($urandom_range(0, 127));
      if (it % 4 == 0) m = 7'h7F;
      irq     = r;
      mascara = m;
      tick();
      elig     = ref_pend & m;
      ref_pend = ref_pend | r;
      if (elig != 0) begin
        ref_win = best(elig);
        chk("rnd_old_word", interrupcion, exp_word());
        serve(int'($urandom_range(0, 4)), 7'($urandom_range(0, 127)));
      end else begin
        chk("rnd_idle_word", interrupcion, 8'h00);
        chk("rnd_idle_busy", 8'(ocupado), 8'd0);
        elig = ref_pend & m;
        if (elig != 0) begin
          tick();
          ref_win = best(elig);
          chk("rnd_word", interrupcion, exp_word());
          serve(int'($urandom_range(0, 4)), 7'($urandom_range(0, 127)));
        end else begin
          irq = '0;
          tick();
          chk("rnd_none_busy", 8'(ocupado), 8'd0);
          chk("rnd_none_word", interrupcion, 8'h00);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/controlador_interrupciones.md
Name: controlador_interrupciones

Overview:
- Generates the 8-bit `interrupcion` word consumed by the monocycle CPU; it is the source end of the CPU interrupt interface.
- Latches rising edges on up to 7 peripheral request lines and applies a mask.
- Picks the highest-priority pending source and emits one framed interrupt word.
- Waits for the CPU acknowledge, retries on timeout and enforces a minimum gap between interrupts.

Parameters:
- PULSE_CYCLES, 1: clock cycles the interrupt word stays valid per issue (≥1).
- GAP_CYCLES, 2: idle cycles forced after an ack or drop before the next issue (≥0).
- TIMEOUT, 16: cycles spent in WAIT_ACK before a retry (≥1).
- MAX_RETRY, 3: re-issues allowed after the first issue before the request is dropped.

Ports:
- clk  input  1: system clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-high reset.
- irq  input  7: peripheral request lines, synchronous to clk; source i carries id i+1.
- mascara  input  7: per-source enable (1 = eligible).
- ack  input  1: CPU acknowledge for the in-service interrupt; level, sampled on clk.
- interrupcion  output  8: [7] valid, [6:4] source id (1..7), [3:0] sequence number.
- ocupado  output  1: high whenever the FSM is not in IDLE.
- perdida  output  1: one-cycle pulse when a request is dropped after MAX_RETRY.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all registers, including `pendiente`, `irq_prev` and the sequence counter `seq`;
  - all outputs, which go to 0 immediately;
  - the FSM, which returns to IDLE.
- Edge detect and pending:
  - `pendiente[i]` sets on any cycle where irq[i]=1 and irq_prev[i]=0.
  - Level-high irq does not re-trigger.
  - Masked sources still latch a pending bit but are not eligible until unmasked.
- Selection: among pendiente & mascara, the highest index wins (id 7 highest).
- FSM states:
  - IDLE: if any eligible bit is set, latch `id_srv`, set retry=0 and go to ISSUE next edge.
  - ISSUE: interrupcion = {1, id_srv, seq} for PULSE_CYCLES cycles, then go to WAIT_ACK. Outputs are registered.
  - WAIT_ACK: interrupcion = 0. On ack, clear pendiente[id_srv-1], seq <= seq+1 (wraps 15→0), go to GAP.
    - After TIMEOUT cycles without ack and retry<MAX_RETRY: retry++, go to ISSUE with the same id and seq.
    - After TIMEOUT cycles with retry==MAX_RETRY: clear the pending bit, pulse perdida, seq++, go to GAP.
  - GAP: wait GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, go straight to IDLE.
- Ack handling:
  - ack is also accepted during ISSUE; the word is truncated (interrupcion=0 next cycle) and the FSM goes to GAP.
  - ack in IDLE or GAP is ignored.
- Latency: rising edge of irq sampled at edge k gives pending set after k, FSM in ISSUE after k+1, so interrupcion is valid in cycle k+1.
- The served source is fixed once in ISSUE. A higher-priority arrival waits; there is no preemption.
- Simultaneous clear and new edge on the same source in one cycle: set wins, so the bit stays pending and is re-served.
- Unmasking a pending source in IDLE makes it eligible the same cycle.
- Masking `id_srv` mid-service does not abort the service.
- Counters are sized $clog2(max+1) and must not overflow at the parameter maxima.

Decomposition:
- Shared package `interrupciones_pkg`:
  - FSM state encoding (IDLE, ISSUE, WAIT_ACK, GAP);
  - field positions of interrupcion (VALID_BIT=7, ID_MSB=6, ID_LSB=4, SEQ_MSB=3);
  - NSRC=7.
- One natural sub-module, `prioridad_int`: a combinational 7-to-3 priority encoder that outputs the id plus an `any` flag.

Test Plan:
- irq[0] rises 0→1 after reset, mascara=7'h7F:
  - interrupcion = 8'b1001_0000 for exactly 1 cycle, one cycle after the sampling edge;
  - ack two cycles later, then interrupcion stays 0 for ≥2 cycles.
- irq[0] and irq[4] rise in the same cycle:
  - first word 8'b1101_0000 (id 5), ack;
  - after the gap, 8'b1001_0001 (id 1, seq 1).
- irq[1] with no ack ever:
  - the word repeats 4 times total, 8'b1010_0000 each, spaced PULSE_CYCLES+TIMEOUT=17 cycles;
  - then perdida pulses once and the pending bit clears.
- irq[2] rises with mascara[2]=0: interrupcion stays 0 and ocupado stays 0. Set mascara[2]=1 and 8'b1011_xxxx issues next cycle.
- Reset asserted mid-ISSUE (async, between edges):
  - interrupcion=0 and ocupado=0 immediately;
  - after release, no stale request reissues and seq restarts at 0.
- 17 consecutive served interrupts: the seq field runs 0..15, then wraps to 0.
